dbus_sram_responder: RTL and testbench



---
 rtl/dbus_sram_responder_pkg.sv | 47 ++++
 rtl/dbus_sram_responder_if.sv | 13 +
 rtl/dbus_sram_responder_sram_1rw_be.sv | 32 +++
 rtl/dbus_sram_responder.sv | 105 ++++++++++
 tb/tb_dbus_sram_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dbus_sram_responder_pkg.sv
// dbus_sram_responder_pkg: shared data-bus types plus the responder's own
// state enum and constants.
//   msize_t       access size (1/2/4/8 bytes)
//   strobe_t      per-byte write enables, 0 means read
//   dbus_req_t    valid, addr, size, strobe, data
//   dbus_resp_t   addr_ok, data_ok, data
//   dresp_state_t responder FSM states
package dbus_sram_responder_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dresp_state_t;

  localparam int unsigned DBUS_WORD_BYTES = 8;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic misaligned(logic [2:0] lo, msize_t sz);
    case (sz)
      MSIZE2:  return lo[0];
      MSIZE4:  return |lo[1:0];
      MSIZE8:  return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// dbus_sram_responder_if: data-bus request/response bundle.
//   dreq   request from the memory stage
//   dresp  response from the responder
//   master modport: requester side; slave modport: responder side
interface dbus_sram_responder_if;
  import dbus_sram_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder_sram_1rw_be.sv
// sram_1rw_be: single-port DEPTH x 64 array split into byte lanes.
//   clk    write clock
//   addr   word index (shared by read and write)
//   we     write enable, qualified per lane by be
//   be     byte enables
//   wdata  write data
//   rdata  combinational read of addr (returns the pre-write word)
// Contents have no reset.
module sram_1rw_be
  import dbus_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic [AW-1:0]       addr,
  input  logic                we,
  input  strobe_t             be,
  input  logic [63:0]         wdata,
  output logic [63:0]         rdata
);

  for (genvar b = 0; b < DBUS_WORD_BYTES; b++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk)
      if (we && be[b]) mem[addr] <= wdata[8*b +: 8];

    assign rdata[8*b +: 8] = mem[addr];
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: data-bus responder backed by an on-chip scratchpad.
// A request seen in IDLE is latched and answered LATENCY cycles later with a
// single addr_ok/data_ok pulse carrying the pre-write word; strobed bytes are
// committed in that same response cycle.
//   clk, reset  clock, asynchronous active-high reset
//   bus         dbus_sram_responder_if.slave (dreq in, dresp out)
//   busy        high while a latched request is outstanding
//   err         pulses with data_ok for a rejected access
// Optional: define DBUS_RESP_RANGE_CHECK_EN to reject out-of-window or
// misaligned accesses (data forced to 0, write suppressed, err raised).
// Without it addresses wrap modulo DEPTH_WORDS and err stays 0.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  dbus_sram_responder_if.slave bus,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dresp_state_t  state, state_nxt;
  logic [3:0]    cnt;
  dbus_req_t     req_q;
  logic [63:0]   offs, rdata;
  logic [AW-1:0] idx;
  logic          accept, bad, we, unused_bits;

  assign accept = (state == IDLE) && bus.dreq.valid;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  // Latched request and countdown; later dreq changes are ignored.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt   <= '0;
      req_q <= '0;
    end else if (accept) begin
      cnt   <= 4'(LATENCY - 1);
      req_q <= bus.dreq;
    end else if (state == WAIT) begin
      cnt   <= cnt - 4'd1;
    end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.dreq.valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Index is relative to BASE_ADDR; the subtraction wraps, giving modulo
  // addressing for out-of-window accesses.
  assign offs = req_q.addr - BASE_ADDR;
  assign idx  = offs[AW+2:3];

  // Byte offset, bits above the window, and the latched valid are not
  // needed for indexing.
  assign unused_bits = ^{offs[63:AW+3], offs[2:0], req_q.valid, req_q.size};

`ifdef DBUS_RESP_RANGE_CHECK_EN
  localparam logic [63:0] END_ADDR =
    BASE_ADDR + 64'(DBUS_WORD_BYTES) * 64'(DEPTH_WORDS);

  assign bad = (req_q.addr < BASE_ADDR) || (req_q.addr >= END_ADDR) ||
               misaligned(req_q.addr[2:0], req_q.size);
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    bus.dresp = '0;
    busy      = (state != IDLE);
    err       = 1'b0;
    we        = 1'b0;
    if (state == RESP) begin
      bus.dresp.addr_ok = 1'b1;
      bus.dresp.data_ok = 1'b1;
      bus.dresp.data    = bad ? 64'd0 : rdata;
      err               = bad;
      we                = (req_q.strobe != '0) && !bad;
    end
  end

  sram_1rw_be #(.DEPTH(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .addr  (idx),
    .we    (we),
    .be    (req_q.strobe),
    .wdata (req_q.data),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dbus_sram_responder.sv
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4096;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic clk = 1'b0, reset = 1'b1;
  logic busy0, err0, busy1, err1;
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  dbus_sram_responder_if bus0();
  dbus_sram_responder_if bus1();

  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .busy(busy0), .err(err0));
  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .busy(busy1), .err(err1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_mem [int unsigned];
  bit          m_pend = 0, m_bad;
  int          m_resp;
  logic [63:0] m_a, m_d;
  strobe_t     m_st;

  function automatic int unsigned widx(logic [63:0] a);
    logic [63:0] o;
    o = a - BASE;
    return int'((o >> 3) % 64'(DEPTH));
  endfunction

  function automatic bit rejected(logic [63:0] a, msize_t sz);
`ifdef DBUS_RESP_RANGE_CHECK_EN
    return (a < BASE) || (a >= BASE + 64'd8 * 64'(DEPTH)) ||
           ((a % (64'd1 << int'(sz))) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] mrd(int unsigned i);
    return m_mem.exists(i) ? m_mem[i] : 64'd0;
  endfunction

  // Expected response: data_ok exactly LAT cycles after acceptance, busy in
  // between, one idle cycle required before the next acceptance.
  always @(negedge clk) begin
    logic        e_ok, e_err;
    logic [63:0] e_d, w;
    e_ok = 0; e_err = 0; e_d = '0;
    if (reset) m_pend = 0;
    else if (m_pend && cyc == m_resp) begin
      e_ok  = 1;
      e_err = m_bad;
      if (!m_bad) e_d = mrd(widx(m_a));
    end
    chk("ctl{aok,dok,busy,err}",
        {bus0.dresp.addr_ok, bus0.dresp.data_ok, busy0, err0},
        {e_ok, e_ok, m_pend, e_err});
    chk("dresp.data", bus0.dresp.data, e_d);
    if (e_ok) begin
      if (!m_bad && m_st != 0) begin
        w = mrd(widx(m_a));
        for (int b = 0; b < 8; b++) if (m_st[b]) w[8*b +: 8] = m_d[8*b +: 8];
        m_mem[widx(m_a)] = w;
      end
      m_pend = 0;
    end else if (!reset && !m_pend && bus0.dreq.valid) begin
      m_pend = 1;
      m_resp = cyc + LAT;
      m_a    = bus0.dreq.addr;
      m_d    = bus0.dreq.data;
      m_st   = bus0.dreq.strobe;
      m_bad  = rejected(bus0.dreq.addr, bus0.dreq.size);
    end
  end

  // ---------------- stimulus ----------------
  int last_ok = 0;

  // Drive one request, hold it until data_ok; optionally scramble addr/data
  // after acceptance. Ends on the data_ok cycle with the request still held.
  task automatic xact(input logic [63:0] a, input msize_t sz, input strobe_t st,
                      input logic [63:0] d, input bit mut,
                      output logic [63:0] rd, output int lat, output logic re);
    dbus_req_t r;
    @(posedge clk); #1;
    r = '{valid: 1'b1, addr: a, size: sz, strobe: st, data: d};
    bus0.dreq = r;
    lat = -1; rd = '0; re = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus0.dresp.data_ok) begin
        lat = k; rd = bus0.dresp.data; re = err0; last_ok = cyc;
        break;
      end
      @(posedge clk); #1;
      if (mut) begin bus0.dreq.addr = a + 64'd8; bus0.dreq.data = ~d; end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus0.dreq = '0;
  endtask

  initial begin
    logic [63:0] rd;
    int          lat, prev;
    logic        re;
    logic [7:0]  pat;
    bus0.dreq = '0;
    bus1.dreq = '0;
    @(negedge clk);
    chk("reset_ctl", {bus0.dresp.addr_ok, bus0.dresp.data_ok, busy0, err0}, 0);
    chk("reset_data", bus0.dresp.data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Known contents for the words used below.
    xact(BASE,                MSIZE8, 8'hFF, 64'hA5A5_0000_5A5A_0001, 0, rd, lat, re); idle();
    xact(64'h8000_0020,       MSIZE8, 8'hFF, 64'h0,                   0, rd, lat, re); idle();
    xact(64'h8000_0038,       MSIZE8, 8'hFF, 64'h0,                   0, rd, lat, re); idle();

    // SD then LD.
    xact(64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 0, rd, lat, re);
    chk("sd_latency", 64'(lat), 2); idle();
    xact(64'h8000_0010, MSIZE8, 8'h00, 64'h0, 0, rd, lat, re);
    chk("ld_data", rd, 64'h1122_3344_5566_7788); idle();

    // SB into byte 3: own response is the old word.
    xact(64'h8000_0013, MSIZE1, 8'h08, 64'h0000_0000_AA00_0000, 0, rd, lat, re);
    chk("sb_old_word", rd, 64'h1122_3344_5566_7788); idle();
    xact(64'h8000_0010, MSIZE8, 8'h00, 64'h0, 0, rd, lat, re);
    chk("sb_merged", rd, 64'h1122_3344_AA66_7788);

    // Back-to-back, valid never dropped.
    prev = last_ok;
    xact(64'h8000_0000, MSIZE8, 8'h00, 64'h0, 0, rd, lat, re);
    chk("b2b_spacing", 64'(last_ok - prev), 3);
    chk("b2b_data", rd, 64'hA5A5_0000_5A5A_0001); idle();

    // Reset during WAIT discards the write and any response.
    @(posedge clk); #1;
    bus0.dreq = '{valid: 1'b1, addr: 64'h8000_0020, size: MSIZE8, strobe: 8'hFF, data: '1};
    @(posedge clk); #1;
    reset = 1'b1; bus0.dreq = '0;
    @(negedge clk);
    chk("rst_mid_ctl", {bus0.dresp.addr_ok, bus0.dresp.data_ok, busy0, err0}, 0);
    chk("rst_mid_data", bus0.dresp.data, 0);
    @(posedge clk); #1 reset = 1'b0;
    xact(64'h8000_0020, MSIZE8, 8'h00, 64'h0, 0, rd, lat, re);
    chk("rst_no_write", rd, 0); idle();

    // Request changes after acceptance are ignored.
    xact(64'h8000_0030, MSIZE8, 8'hFF, 64'hCAFE_F00D_1234_5678, 1, rd, lat, re);
    chk("mut_latency", 64'(lat), 2); idle();
    xact(64'h8000_0030, MSIZE8, 8'h00, 64'h0, 0, rd, lat, re);
    chk("mut_latched", rd, 64'hCAFE_F00D_1234_5678); idle();
    xact(64'h8000_0038, MSIZE8, 8'h00, 64'h0, 0, rd, lat, re);
    chk("mut_neighbour", rd, 0); idle();

`ifdef DBUS_RESP_RANGE_CHECK_EN
    xact(64'h7FFF_FFF8, MSIZE8, 8'h00, 64'h0, 0, rd, lat, re);
    chk("oor_data", rd, 0);
    chk("oor_err", 64'(re), 1); idle();
    xact(64'h8000_0002, MSIZE4, 8'h3C, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, lat, re);
    chk("misalign_err", 64'(re), 1);
    chk("misalign_lat", 64'(lat), 2); idle();
    xact(BASE, MSIZE8, 8'h00, 64'h0, 0, rd, lat, re);
    chk("misalign_nowrite", rd, 64'hA5A5_0000_5A5A_0001);
    chk("inrange_err", 64'(re), 0); idle();
`else
    xact(BASE + 64'd8 * 64'(DEPTH), MSIZE8, 8'h00, 64'h0, 0, rd, lat, re);
    chk("wrap_data", rd, 64'hA5A5_0000_5A5A_0001);
    chk("wrap_err", 64'(re), 0); idle();
`endif

    // LATENCY=1 instance: held valid gives data_ok every other cycle.
    @(posedge clk); #1;
    bus1.dreq = '{valid: 1'b1, addr: BASE, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pat[k] = bus1.dresp.data_ok;
    end
    bus1.dreq = '0;
    chk("lat1_pattern", 64'(pat), 64'hAA);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
